// File: rtl/rsa_key_sequencer.sv
// RSA key-setup sequencer: drives the modulus/totient block, then searches for the
// smallest odd public exponent e >= seed that is coprime to phi, using binary GCD.
`timescale 1ns/1ps
module rsa_key_sequencer #(
    parameter int SIZE = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE-1:0]   p,
    input  logic [SIZE-1:0]   q,
    input  logic [2*SIZE-1:0] e_seed,
    output logic [SIZE-1:0]   mt_in1,
    output logic [SIZE-1:0]   mt_in2,
    output logic              mt_enabled,
    input  logic [2*SIZE-1:0] mt_modulus,
    input  logic [2*SIZE-1:0] mt_totient,
    input  logic              mt_finished,
    output logic [2*SIZE-1:0] n,
    output logic [2*SIZE-1:0] phi,
    output logic [2*SIZE-1:0] e,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int W2 = 2 * SIZE;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_GCD   = 3'd3;
    localparam logic [2:0] ST_NEXT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERR   = 3'd6;

    logic [2:0]    state;
    logic [W2-1:0] e_cand;
    logic [W2-1:0] a;
    logic [W2-1:0] b;

    logic [W2-1:0] seed_odd;
    logic [W2-1:0] seed_cand;
    logic          primes_bad;
    logic          cand_too_big;

    always_comb begin
        seed_odd     = {e_seed[W2-1:1], 1'b1};
        seed_cand    = (seed_odd < W2'(3)) ? W2'(3) : seed_odd;
        primes_bad   = (p < SIZE'(3)) || (q < SIZE'(3));
        // One extra bit keeps the compare safe against any phi the block returns.
        cand_too_big = ({1'b0, e_cand} >= {1'b0, phi});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            mt_in1     <= '0;
            mt_in2     <= '0;
            mt_enabled <= 1'b0;
            n          <= '0;
            phi        <= '0;
            e          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            e_cand     <= '0;
            a          <= '0;
            b          <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        done   <= 1'b0;
                        error  <= 1'b0;
                        n      <= '0;
                        phi    <= '0;
                        e      <= '0;
                        e_cand <= seed_cand;
                        if (primes_bad) begin
                            error <= 1'b1;
                            state <= ST_ERR;
                        end else begin
                            mt_in1     <= p;
                            mt_in2     <= q;
                            mt_enabled <= 1'b1;
                            busy       <= 1'b1;
                            state      <= ST_LOAD;
                        end
                    end
                end

                ST_LOAD: begin
                    if (mt_finished) begin
                        n          <= mt_modulus;
                        phi        <= mt_totient;
                        mt_enabled <= 1'b0;
                        state      <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (cand_too_big) begin
                        busy  <= 1'b0;
                        error <= 1'b1;
                        state <= ST_ERR;
                    end else begin
                        a     <= phi;
                        b     <= e_cand;
                        state <= ST_GCD;
                    end
                end

                // b starts odd, so dropping factors of two never changes the gcd.
                ST_GCD: begin
                    if (a == b) begin
                        if (a == W2'(1)) begin
                            e     <= e_cand;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_NEXT;
                        end
                    end else if (!a[0]) begin
                        a <= a >> 1;
                    end else if (!b[0]) begin
                        b <= b >> 1;
                    end else if (a > b) begin
                        a <= a - b;
                    end else begin
                        b <= b - a;
                    end
                end

                ST_NEXT: begin
                    e_cand <= e_cand + W2'(2);
                    state  <= ST_CHECK;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
